moment_ram: RTL and testbench
=============================

# moment_ram

Single-port synchronous RAM that holds one signed macroscopic moment value per lattice node of the LBM grid. The default is a 16×16 grid, so there are 256 words of 32 bits each. The moment-update stage writes one value per clock, and downstream stages read it back one cycle later. The design maps onto an FPGA block RAM that has a registered output.

## Interface
Parameters:
- DEPTH, default 256 (16*16): number of words, one per lattice node.
- ADDRESS_WIDTH, default $clog2(DEPTH) = 8: address bus width.
- DATA_WIDTH, default 32: word width, two's-complement signed.

Ports:
- Clk, input, 1: single clock; all state changes on the rising edge.
- Reset_n, input, 1: asynchronous, active-low reset.
- WE, input, 1: write enable, sampled on the rising edge of Clk.
- address, input, ADDRESS_WIDTH: word address for both reads and writes.
- data_in, input, signed DATA_WIDTH: write data.
- data_out, output, signed DATA_WIDTH: registered read data.

## Operation
- Storage is an array of DEPTH words, each signed DATA_WIDTH bits.
- Power-up content is all words 0, set by the initialiser.
- Reset does not clear the array. This keeps block-RAM inference possible.
- Write: on a rising edge with WE=1 and address < DEPTH, mem[address] <= data_in.
- Read: on every rising edge, the data_out register is loaded, whatever the value of WE.
  - With WE=0, address < DEPTH: data_out <= mem[address].
  - With WE=1, address < DEPTH: write-first, so data_out <= data_in (the new value).
  - With address >= DEPTH (only possible when DEPTH is not a power of 2): the write is ignored and data_out <= 0.
- Data is stored and returned bit-exact. There is no sign extension, saturation or arithmetic.
- Reset (Reset_n=0):
  - data_out is forced to 0 immediately, without waiting for a clock.
  - While reset is held, writes are blocked and data_out stays at 0.
  - Memory contents are retained through reset.
- Reset released mid-operation: the first rising edge after Reset_n goes to 1 performs a normal read or write.
- X or undriven data_in with WE=0 has no effect on the array.

## Timing
- Write latency: data is committed at the rising edge where WE=1 is sampled.
- Read latency: 1 cycle. The address sampled at edge N appears on data_out after edge N and holds until edge N+1.
- Back-to-back operations are supported every cycle, in any mix of reads and writes.
- Write followed by read of the same address on the next edge returns the new value.
- Inputs must meet setup and hold around the rising edge of Clk. Changes between edges have no effect.
- Reset assertion is asynchronous. Reset deassertion is expected to be synchronised upstream.
- data_out reset value: 0.

## Test plan
- Reset, then read: assert Reset_n=0 while data_out is nonzero, so data_out goes to 0 before the next edge. Release reset, read address 0x05 from power-up state, and data_out = 0x00000000 after 1 edge.
- Write-first: WE=1, address 0x00, data_in 0x12345678 for one edge. data_out = 0x12345678 after that edge. Then WE=0, address 0x00, and data_out = 0x12345678 on the next edge.
- Two writes, then reads:
  - Write 0x12345678 to 0x00.
  - Write 0xABCCCDEF to 0x12, with address and data changed mid-cycle before the edge.
  - With WE=0, read 0x12 gives 0xABCCCDEF and read 0x00 gives 0x12345678.
- Full range and sign:
  - Write addr 0xFF = 0x80000000 and addr 0x01 = 0xFFFFFFFF.
  - Readback is bit-exact, with no aliasing onto 0x00 or 0x7F.
- Reset preserves memory:
  - Write 0xDEADBEEF to 0x40, then pulse Reset_n low mid-cycle; data_out goes to 0 immediately.
  - While Reset_n is low, drive WE=1, address 0x41, data 0x11111111 across an edge.
  - After release, read 0x40 gives 0xDEADBEEF and read 0x41 gives 0.
- Streaming: write addr i = i*3 for i = 0..255 on consecutive cycles, then read 0..255 on consecutive cycles. Each data_out equals the expected value exactly one cycle after its address.

Source files
------------

// File: rtl/moment_ram.sv
// moment_ram: single-port RAM holding one signed moment per lattice node.
// Write-first, 1-cycle registered read, async active-low output reset.
//
// Ports:
//   Clk      - clock, all state changes on the rising edge
//   Reset_n  - asynchronous active-low reset (clears data_out only)
//   WE       - write enable
//   address  - word address for reads and writes
//   data_in  - signed write data
//   data_out - signed registered read data
module moment_ram #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 32
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         WE,
    input  logic [ADDRESS_WIDTH-1:0]     address,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [DATA_WIDTH-1:0] data_out
);

    // One extra bit so DEPTH itself is representable.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);

    // Power-up content is zero; no reset on the array so it maps to block RAM.
    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic signed [DATA_WIDTH-1:0] data_out_d;
    logic                         in_range;
    logic                         wr_en;

    assign in_range = ({1'b0, address} < DEPTH_W);

    // Reset_n gates writes so an edge during reset leaves the array intact.
    assign wr_en = Reset_n && WE && in_range;

    // Write-first read path; out-of-range addresses read as zero.
    always_comb begin
        data_out_d = '0;
        if (in_range) begin
            if (WE) begin
                data_out_d = data_in;
            end else begin
                data_out_d = mem_q[address];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[address] <= data_in;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_moment_ram.sv
// tb_moment_ram: randomized and directed checks of moment_ram
// against an array-based reference model.
module tb_moment_ram;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic                 Clk;
    logic                 Reset_n;
    logic                 WE;
    logic [AW-1:0]        address;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;

    int n_checks;
    int n_fail;

    // Reference: memory contents and the value data_out should hold.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_out;

    moment_ram #(
        .DEPTH(DEPTH),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .WE(WE),
        .address(address),
        .data_in(data_in),
        .data_out(data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One clocked operation: drive at negedge, advance model, sample 1ns after edge.
    task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge Clk);
        WE = we;
        address = a;
        data_in = d;
        @(posedge Clk);
        #1;
        if (we) model[a] = d;
        exp_out = model[a];
    endtask

    task automatic test_reset();
        #1 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", data_out, 32'h0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle(1'b1, 8'h03, 32'h0000_0055);
        n_checks++;
        if (data_out !== 32'h0000_0055) begin
            n_fail++;
            $display("FAIL reset_preload: got %h expected %h", data_out, 32'h0000_0055);
        end
        #1 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", data_out, 32'h0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle(1'b0, 8'h05, 32'h0);
        n_checks++;
        if (data_out !== 32'h0 || data_out !== exp_out) begin
            n_fail++;
            $display("FAIL reset_read05: got %h expected %h", data_out, 32'h0);
        end
    endtask

    task automatic test_write_first();
        cycle(1'b1, 8'h00, 32'h1234_5678);
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wf_write: got %h expected %h", data_out, 32'h1234_5678);
        end
        cycle(1'b0, 8'h00, 32'hFFFF_0000);
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wf_read: got %h expected %h", data_out, 32'h1234_5678);
        end
    endtask

    task automatic test_two_writes();
        cycle(1'b1, 8'h00, 32'h1234_5678);
        // Inputs change mid-cycle; only the value at the edge matters.
        @(negedge Clk);
        WE = 1'b1;
        address = 8'h34;
        data_in = 32'h5555_AAAA;
        #2;
        address = 8'h12;
        data_in = 32'hABCC_CDEF;
        @(posedge Clk);
        #1;
        model[8'h12] = 32'hABCC_CDEF;
        n_checks++;
        if (data_out !== 32'hABCC_CDEF) begin
            n_fail++;
            $display("FAIL tw_write12: got %h expected %h", data_out, 32'hABCC_CDEF);
        end
        cycle(1'b0, 8'h12, 32'h0);
        n_checks++;
        if (data_out !== 32'hABCC_CDEF) begin
            n_fail++;
            $display("FAIL tw_read12: got %h expected %h", data_out, 32'hABCC_CDEF);
        end
        cycle(1'b0, 8'h00, 32'h0);
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL tw_read00: got %h expected %h", data_out, 32'h1234_5678);
        end
        cycle(1'b0, 8'h34, 32'h0);
        n_checks++;
        if (data_out !== exp_out) begin
            n_fail++;
            $display("FAIL tw_read34: got %h expected %h", data_out, exp_out);
        end
    endtask

    task automatic test_full_range();
        logic [AW-1:0] addrs [4];
        addrs = '{8'hFF, 8'h01, 8'h00, 8'h7F};
        cycle(1'b1, 8'hFF, 32'h8000_0000);
        cycle(1'b1, 8'h01, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, addrs[i], 32'h0);
            n_checks++;
            if (data_out !== exp_out) begin
                n_fail++;
                $display("FAIL range_read%h: got %h expected %h", addrs[i], data_out, exp_out);
            end
        end
    endtask

    task automatic test_reset_preserves();
        cycle(1'b1, 8'h40, 32'hDEAD_BEEF);
        #1 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rp_async: got %h expected %h", data_out, 32'h0);
        end
        @(negedge Clk);
        WE = 1'b1;
        address = 8'h41;
        data_in = 32'h1111_1111;
        @(posedge Clk);
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rp_held: got %h expected %h", data_out, 32'h0);
        end
        @(negedge Clk);
        WE = 1'b0;
        Reset_n = 1'b1;
        cycle(1'b0, 8'h40, 32'h0);
        n_checks++;
        if (data_out !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rp_read40: got %h expected %h", data_out, 32'hDEAD_BEEF);
        end
        cycle(1'b0, 8'h41, 32'h0);
        n_checks++;
        if (data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rp_read41: got %h expected %h", data_out, 32'h0);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, AW'(i), DW'(i * 3));
            n_checks++;
            if (data_out !== DW'(i * 3)) begin
                n_fail++;
                $display("FAIL stream_wr%0d: got %h expected %h", i, data_out, DW'(i * 3));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, AW'(i), 32'hFFFF_FFFF);
            n_checks++;
            if (data_out !== DW'(i * 3)) begin
                n_fail++;
                $display("FAIL stream_rd%0d: got %h expected %h", i, data_out, DW'(i * 3));
            end
        end
    endtask

    task automatic test_random();
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 15));
            d  = $urandom;
            cycle(we, a, d);
            n_checks++;
            if (data_out !== exp_out) begin
                n_fail++;
                $display("FAIL random%0d: addr %h we %b got %h expected %h",
                         i, a, we, data_out, exp_out);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_out = '0;
        Reset_n = 1'b1;
        WE = 1'b0;
        address = '0;
        data_in = '0;
        test_reset();
        test_write_first();
        test_two_writes();
        test_full_range();
        test_reset_preserves();
        test_streaming();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
